// File: rtl/thread_sched_if.sv
`default_nettype none
// +---------------------------------------------------------------+
// | thread_sched_if : launch, fetch, ALU and status bundle        |
// | Revision: 1.0                                                 |
// +---------------------------------------------------------------+
interface thread_sched_if #(
  parameter int NT   = 4,
  parameter int PC_W = 12
);
  localparam int TID_W = $clog2(NT);

  logic             start_valid;
  logic [TID_W-1:0] start_tid;
  logic [PC_W-1:0]  start_pc;
  logic             start_ready;
  logic             fetch_valid;
  logic [PC_W-1:0]  fetch_addr;
  logic [15:0]      fetch_data;
  logic             alu_valid;
  logic [15:0]      alu_ins;
  logic [TID_W-1:0] alu_tid;
  logic             branch_en;
  logic [15:0]      branch_val;
  logic [NT-1:0]    active;
  logic             all_halted;

  modport slave (
    input  start_valid, start_tid, start_pc, fetch_data, branch_en, branch_val,
    output start_ready, fetch_valid, fetch_addr, alu_valid, alu_ins, alu_tid,
           active, all_halted
  );

  modport master (
    output start_valid, start_tid, start_pc, fetch_data, branch_en, branch_val,
    input  start_ready, fetch_valid, fetch_addr, alu_valid, alu_ins, alu_tid,
           active, all_halted
  );
endinterface
`default_nettype wire

// File: rtl/thread_sched.sv
`default_nettype none
// +---------------------------------------------------------------+
// | thread_sched : round-robin barrel scheduler, 3-stage pipeline |
// | Revision: 1.0                                                 |
// +---------------------------------------------------------------+
module thread_sched #(
  parameter int NT   = 4,
  parameter int PC_W = 12
) (
  input  wire logic     clk,
  input  wire logic     rst,
  thread_sched_if.slave bus
);
  localparam int TID_W = $clog2(NT);
  typedef logic [TID_W-1:0] tid_t;

  logic [PC_W-1:0] pc_q [NT];
  logic [PC_W-1:0] pc_d [NT];
  logic [NT-1:0]   active_q, active_d;
  logic [NT-1:0]   busy_q, busy_d;
  tid_t            last_grant_q, last_grant_d;
  logic            s1_valid_q, s1_valid_d;
  tid_t            s1_tid_q, s1_tid_d;
  logic            s2_valid_q, s2_valid_d;
  tid_t            s2_tid_q, s2_tid_d;
  logic [3:0]      s2_op_q, s2_op_d;

  logic            start_acc;
  logic [NT-1:0]   start_mask;
  logic [NT-1:0]   eligible;
  logic            pick_valid;
  tid_t            pick_tid;
  tid_t            cand;
  logic            alu_valid_w;
  logic            unused_branch_bits;

  assign unused_branch_bits = ^bus.branch_val[15:PC_W];

  // A thread being launched this cycle is masked out of arbitration.
  always_comb begin
    start_mask             = '0;
    start_mask[bus.start_tid] = 1'b1;
    start_acc              = bus.start_valid && !busy_q[bus.start_tid];
    eligible               = active_q & ~busy_q & ~(start_acc ? start_mask : '0);
    pick_valid             = 1'b0;
    pick_tid               = '0;
    cand                   = '0;
    for (int i = 1; i <= NT; i++) begin
      cand = last_grant_q + tid_t'(i);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_tid   = cand;
      end
    end
  end

  always_comb begin
    pc_d         = pc_q;
    active_d     = active_q;
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    s1_valid_d   = pick_valid;
    s1_tid_d     = pick_tid;
    s2_valid_d   = s1_valid_q;
    s2_tid_d     = s1_tid_q;
    s2_op_d      = bus.fetch_data[15:12];

    if (pick_valid) begin
      busy_d[pick_tid] = 1'b1;
      last_grant_d     = pick_tid;
    end

    // HALT retires the thread without touching its pc or honouring a branch.
    if (s2_valid_q) begin
      busy_d[s2_tid_q] = 1'b0;
      if (s2_op_q == 4'hF) begin
        active_d[s2_tid_q] = 1'b0;
      end else if (bus.branch_en) begin
        pc_d[s2_tid_q] = bus.branch_val[PC_W-1:0];
      end else begin
        pc_d[s2_tid_q] = pc_q[s2_tid_q] + PC_W'(1);
      end
    end

    if (start_acc) begin
      pc_d[bus.start_tid]     = bus.start_pc;
      active_d[bus.start_tid] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        pc_q[t] <= '0;
      end
      active_q     <= NT'(1);
      busy_q       <= '0;
      last_grant_q <= tid_t'(NT - 1);
      s1_valid_q   <= 1'b0;
      s1_tid_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_tid_q     <= '0;
      s2_op_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      active_q     <= active_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_tid_q     <= s1_tid_d;
      s2_valid_q   <= s2_valid_d;
      s2_tid_q     <= s2_tid_d;
      s2_op_q      <= s2_op_d;
    end
  end

  assign alu_valid_w     = s1_valid_q & ~rst;
  assign bus.start_ready = ~busy_q[bus.start_tid];
  assign bus.fetch_valid = pick_valid & ~rst;
  assign bus.fetch_addr  = pc_q[pick_tid];
  assign bus.alu_valid   = alu_valid_w;
  assign bus.alu_ins     = alu_valid_w ? bus.fetch_data : 16'h0000;
  assign bus.alu_tid     = rst ? '0 : s1_tid_q;
  assign bus.active      = active_q;
  assign bus.all_halted  = ~rst & ~(|active_q) & ~s1_valid_q & ~s2_valid_q;
endmodule
`default_nettype wire

// File: doc/thread_sched.md
THREAD_SCHED -- requirements
Module: thread_sched

Interface
REQ-001 Parameter NT, default 4, number of hardware threads; tid width is 2.
REQ-002 Parameter PC_W, default 12, program counter width, matching the 12-bit branch target field ins[11:0].
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_valid  in  1  request to launch a thread.
REQ-006 start_tid  in  2  thread to launch.
REQ-007 start_pc  in  12  launch address.
REQ-008 start_ready  out  1  high when start_tid is not busy; start accepted only when start_valid && start_ready.
REQ-009 fetch_valid  out  1  instruction fetch request this cycle.
REQ-010 fetch_addr  out  12  PC of selected thread.
REQ-011 fetch_data  in  16  instruction memory read data, valid the cycle after fetch_valid (synchronous memory).
REQ-012 alu_valid  out  1  alu_ins carries a real instruction.
REQ-013 alu_ins  out  16  instruction to ALU ins_in; 16'h0000 (no-op) when alu_valid low.
REQ-014 alu_tid  out  2  owning thread of alu_ins.
REQ-015 branch_en  in  1  ALU branch-taken, combinational, for the instruction sent one cycle earlier.
REQ-016 branch_val  in  16  ALU branch target; only [11:0] used.
REQ-017 active  out  4  per-thread runnable mask (not halted).
REQ-018 all_halted  out  1  high when active == 4'b0000 and pipeline is empty.

Function
REQ-019 Three-stage pipeline per instruction: S0 select/fetch (cycle N), S1 forward to ALU (N+1), S2 resolve (N+2).
REQ-020 S0: eligible = active & ~busy; round-robin pick starting at last_grant+1 mod 4; if none eligible, fetch_valid=0.
REQ-021 On pick: fetch_valid=1, fetch_addr=pc[t], busy[t] set at the same clock edge, last_grant<=t.
REQ-022 S1: alu_valid, alu_tid are the registered S0 valid/tid; alu_ins = fetch_data when valid, else 16'h0000.
REQ-023 S2: registered S1 valid/tid/opcode; when valid, update pc[tid] and clear busy[tid] at the end of N+2.
REQ-024 PC update: branch_en=1 -> pc<=branch_val[11:0]; else pc<=pc+1 modulo 2^12 (12'hFFF wraps to 12'h000).
REQ-025 Opcode 4'hF (HALT) at S2: clear active[tid], pc unchanged; branch_en ignored for HALT.
REQ-026 A thread resolved at N+2 is eligible again at N+3 (one thread issues at most once per 3 cycles).
REQ-027 With >=3 active threads, fetch_valid holds high every cycle (full throughput).
REQ-028 Accepted start: pc[start_tid]<=start_pc, active[start_tid]<=1; start on an already-active, non-busy thread restarts it at start_pc.
REQ-029 start_ready = ~busy[start_tid]; a start to a busy thread is ignored and has no side effects.
REQ-030 Same-cycle S2 resolve and accepted start cannot target the same thread (busy blocks start); different threads both apply.
REQ-031 Same-cycle S0 pick and accepted start to the same thread: start wins, pick of that thread suppressed that cycle, arbitration proceeds to next eligible.

Reset
REQ-032 While rst high: pc[all]=0, active=4'b0001, busy=0, last_grant=3, S1/S2 valids=0.
REQ-033 Outputs during reset cycle: fetch_valid=0, alu_valid=0, alu_ins=16'h0000, alu_tid=0, all_halted=0.
REQ-034 rst asserted mid-operation discards all in-flight instructions; no pc update from them.
REQ-035 First cycle after rst release: fetch_valid=1, fetch_addr=12'h000, thread 0.

Verification
REQ-036 Reset release, memory all 16'h1000 (PLUS): fetch_addr 0,1,2 on cycles 0,3,6; alu_tid=0 each.
REQ-037 Start threads 1,2,3 at 12'h100,12'h200,12'h300: fetch order 0,1,2,3,0,... with fetch_valid continuously high.
REQ-038 Thread 0 BRZ 5'h5 with branch_en=1, branch_val=16'h0042: next fetch_addr for thread 0 = 12'h042.
REQ-039 Thread at pc 12'hFFF, non-branch instruction: next fetch_addr 12'h000.
REQ-040 Only thread 0 active, fetches 16'hF000: active->0 at N+2, all_halted=1 from N+3, fetch_valid stays 0; start_valid tid 0 pc 12'h010 -> fetch 12'h010 next cycle.
REQ-041 rst pulsed with 3 instructions in flight: alu_valid=0 next cycle, pc[0]=0, active=4'b0001.
